// File: rtl/opb_register_simulink2ppc_if.sv
// ----------------------------------------------------------------------------
// opb_register_simulink2ppc_if
//   OPB slave-side bus bundle for the Simulink-to-PPC register.
//   Signal names and bit orders follow the OPB convention (bit 0 = MSB).
//
//   OPB_ABus    [0:31]  address              (master -> slave)
//   OPB_BE      [0:3]   byte enables         (master -> slave)
//   OPB_DBus    [0:31]  write data           (master -> slave)
//   OPB_RNW             1 = read, 0 = write  (master -> slave)
//   OPB_select          transfer in progress (master -> slave)
//   OPB_seqAddr         sequential hint      (master -> slave, ignored)
//   Sl_DBus     [0:31]  read data            (slave -> master)
//   Sl_xferAck          transfer acknowledge (slave -> master)
//   Sl_errAck, Sl_retry, Sl_toutSup          (slave -> master, tied 0)
// ----------------------------------------------------------------------------
interface opb_register_simulink2ppc_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_simulink2ppc.sv
// ----------------------------------------------------------------------------
// opb_register_simulink2ppc
//   OPB slave register carrying a 32-bit fabric value to the PowerPC.
//   Fabric logic strobes user_valid with user_data_in; the word is captured,
//   new/overflow status is tracked, and the PPC reads it over OPB.
//
//   Register map (word offsets inside a 256-byte window):
//     0x00 DATA    RO  captured word (user_data_in[31] -> Sl_DBus[0])
//     0x04 STATUS  RO  [31]=new, [30]=overflow, [0:15]=capture count
//     0x08 CONTROL WO  when BE[3]: [31]=1 clears overflow, [30]=1 clears count
//     0x0C         reads 0, writes ignored
//
//   Ports:
//     OPB_Clk       single clock for bus and capture logic
//     OPB_Rst       synchronous active-high reset
//     opb           OPB slave modport (see opb_register_simulink2ppc_if)
//     user_data_in  fabric value
//     user_valid    capture strobe, one cycle per value
//
//   Build option: define S2P_CAPTURE_COUNT_EN to build the 16-bit saturating
//   capture counter. Without it STATUS[0:15] reads 0 and CONTROL[30] is ignored.
// ----------------------------------------------------------------------------
module opb_register_simulink2ppc #(
    parameter logic [0:31] C_BASEADDR   = 32'hFFFFFFFF,
    parameter logic [0:31] C_HIGHADDR   = 32'h00000000,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic                          OPB_Clk,
    input  logic                          OPB_Rst,
    opb_register_simulink2ppc_if.slave    opb,
    input  logic [31:0]                   user_data_in,
    input  logic                          user_valid
);

    // Elaboration-time sanity check of the bus configuration.
    if (C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32 ||
        (C_HIGHADDR != 32'h0 && C_HIGHADDR[0:23] != C_BASEADDR[0:23])) begin : g_bad_cfg
        $error("opb_register_simulink2ppc: unsupported bus configuration");
    end

    logic        w_hit;
    logic        w_start;
    logic [1:0]  w_off;
    logic        w_ctrl_wr;
    logic [0:31] w_status;
    logic [0:31] w_rdata;
    logic        w_new_d;
    logic        w_ovf_d;

    logic        r_ack;
    logic        r_done;
    logic [0:31] r_dbus;
    logic [31:0] r_data;
    logic        r_new;
    logic        r_ovf;
    // Side-effect flags: captured in the hit cycle, high only during the ack
    // cycle, applied on the edge that ends it.
    logic        r_clr_new;
    logic        r_clr_ovf;

`ifdef S2P_CAPTURE_COUNT_EN
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_d;
    logic        r_clr_cnt;
`endif

    always_comb begin
        w_hit   = opb.OPB_select && (opb.OPB_ABus[0:23] == C_BASEADDR[0:23]);
        w_off   = {opb.OPB_ABus[28], opb.OPB_ABus[29]};
        // r_done blocks a re-ack while the master keeps select on the same hit.
        w_start = w_hit && !r_ack && !r_done && !OPB_Rst;

        w_status     = '0;
        w_status[31] = r_new;
        w_status[30] = r_ovf;
`ifdef S2P_CAPTURE_COUNT_EN
        w_status[0:15] = r_cnt;
`endif

        w_rdata = '0;
        if (opb.OPB_RNW) begin
            case (w_off)
                2'd0:    w_rdata = r_data;
                2'd1:    w_rdata = w_status;
                default: w_rdata = '0;
            endcase
        end

        w_ctrl_wr = w_start && !opb.OPB_RNW && (w_off == 2'd2) && opb.OPB_BE[3];

        // A capture always leaves new set, even against a DATA-read clear.
        w_new_d = r_new;
        if (r_clr_new) w_new_d = 1'b0;
        if (user_valid) w_new_d = 1'b1;

        // Overflow only when unread data is overwritten; a capture coinciding
        // with the DATA-read clear does not count. A clear beats a set.
        w_ovf_d = r_ovf;
        if (user_valid && r_new && !r_clr_new) w_ovf_d = 1'b1;
        if (r_clr_ovf) w_ovf_d = 1'b0;

`ifdef S2P_CAPTURE_COUNT_EN
        w_cnt_d = r_cnt;
        if (user_valid && r_cnt != 16'hFFFF) w_cnt_d = r_cnt + 16'd1;
        if (r_clr_cnt) w_cnt_d = user_valid ? 16'd1 : 16'd0;
`endif
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_ack     <= 1'b0;
            r_done    <= 1'b0;
            r_dbus    <= '0;
            r_data    <= '0;
            r_new     <= 1'b0;
            r_ovf     <= 1'b0;
            r_clr_new <= 1'b0;
            r_clr_ovf <= 1'b0;
        end else begin
            r_ack     <= w_start;
            r_done    <= (r_ack || r_done) && w_hit;
            // Read data only ever lives in the ack cycle.
            r_dbus    <= w_start ? w_rdata : '0;
            r_clr_new <= w_start && opb.OPB_RNW && (w_off == 2'd0);
            r_clr_ovf <= w_ctrl_wr && opb.OPB_DBus[31];
            if (user_valid) r_data <= user_data_in;
            r_new     <= w_new_d;
            r_ovf     <= w_ovf_d;
        end
    end

`ifdef S2P_CAPTURE_COUNT_EN
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_cnt     <= '0;
            r_clr_cnt <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_d;
            r_clr_cnt <= w_ctrl_wr && opb.OPB_DBus[30];
        end
    end
`endif

    assign opb.Sl_DBus    = r_dbus;
    assign opb.Sl_xferAck = r_ack;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    logic w_unused;
    assign w_unused = ^{opb.OPB_seqAddr, opb.OPB_ABus[24:27], opb.OPB_ABus[30:31],
                        opb.OPB_BE[0:2], opb.OPB_DBus[0:30], C_FAMILY.len()};

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// ----------------------------------------------------------------------------
// tb_opb_register_simulink2ppc
//   Self-checking bench for opb_register_simulink2ppc: a vector table of
//   captures and OPB transfers, expected read data queued at drive time and
//   popped on Sl_xferAck, plus sequences for held select, out-of-window,
//   reset during a transfer and counter saturation.
// ----------------------------------------------------------------------------
module tb_opb_register_simulink2ppc;
    localparam logic [31:0] BASE = 32'h80001000;
`ifdef S2P_CAPTURE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
    localparam int NSAT   = 65600;
`else
    localparam bit CNT_EN = 1'b0;
    localparam int NSAT   = 40;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] udata;
    logic        uvalid;

    always #5 clk = ~clk;

    opb_register_simulink2ppc_if bus ();

    opb_register_simulink2ppc #(
        .C_BASEADDR  (BASE),
        .C_HIGHADDR  (BASE + 32'hFF),
        .C_OPB_AWIDTH(32),
        .C_OPB_DWIDTH(32),
        .C_FAMILY    ("virtex5")
    ) dut (
        .OPB_Clk     (clk),
        .OPB_Rst     (rst),
        .opb         (bus),
        .user_data_in(udata),
        .user_valid  (uvalid)
    );

    typedef struct {
        int          ncap;
        logic [31:0] cap0;
        logic [31:0] cap1;
        logic        rnw;
        logic [7:0]  off;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        cap_ack;
        logic [31:0] capv;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] st(input logic [15:0] cnt, input logic ovf, input logic nw);
        return {(CNT_EN ? cnt : 16'h0000), 14'b0, ovf, nw};
    endfunction

    task automatic add(input int ncap, input logic [31:0] c0, input logic [31:0] c1,
                       input logic rnw, input logic [7:0] off, input logic [3:0] be,
                       input logic [31:0] wd, input logic cap_ack, input logic [31:0] capv,
                       input logic [31:0] exp);
        vec_t v;
        v.ncap = ncap; v.cap0 = c0; v.cap1 = c1; v.rnw = rnw; v.off = off; v.be = be;
        v.wd = wd; v.cap_ack = cap_ack; v.capv = capv; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic capture(input logic [31:0] v);
        @(posedge clk); #1;
        uvalid = 1'b1;
        udata  = v;
        @(posedge clk); #1;
        uvalid = 1'b0;
    endtask

    task automatic xfer(input string name, input logic rnw, input logic [7:0] off,
                        input logic [3:0] be, input logic [31:0] wd, input logic cap_ack,
                        input logic [31:0] capv, input logic [31:0] exp);
        int n;
        logic [31:0] e;
        @(posedge clk); #1;
        bus.OPB_ABus   = BASE | {24'h0, off};
        bus.OPB_RNW    = rnw;
        bus.OPB_BE     = be;
        bus.OPB_DBus   = rnw ? 32'h0 : wd;
        bus.OPB_select = 1'b1;
        exp_q.push_back(exp);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.Sl_xferAck && n < 8);
        chk({name, " ack latency"}, n, 1);
        e = exp_q.pop_front();
        if (bus.Sl_xferAck) chk({name, " data"}, bus.Sl_DBus, e);
        bus.OPB_select = 1'b0;
        if (cap_ack) begin
            uvalid = 1'b1;
            udata  = capv;
        end
        @(posedge clk); #1;
        uvalid = 1'b0;
        chk({name, " ack drop"}, {31'b0, bus.Sl_xferAck}, 32'h0);
    endtask

    initial begin
        int acks;
        logic [31:0] e;

        rst = 1'b1; uvalid = 1'b0; udata = '0;
        bus.OPB_ABus = '0; bus.OPB_BE = '0; bus.OPB_DBus = '0;
        bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ack", {31'b0, bus.Sl_xferAck}, 32'h0);
        chk("reset dbus", bus.Sl_DBus, 32'h0);
        rst = 1'b0;

        //   ncap cap0          cap1   rnw  off    be       wd            cap_ack capv   exp
        add(0, 0,            0,     1, 8'h00, 4'hF, 0,            0, 0,     32'h0);
        add(0, 0,            0,     1, 8'h04, 4'hF, 0,            0, 0,     st(0, 0, 0));
        add(1, 32'hDEADBEEF, 0,     1, 8'h04, 4'hF, 0,            0, 0,     st(1, 0, 1));
        add(0, 0,            0,     1, 8'h00, 4'hF, 0,            0, 0,     32'hDEADBEEF);
        add(0, 0,            0,     1, 8'h04, 4'hF, 0,            0, 0,     st(1, 0, 0));
        add(2, 32'h1,        32'h2, 1, 8'h04, 4'hF, 0,            0, 0,     st(3, 1, 1));
        add(0, 0,            0,     1, 8'h00, 4'hF, 0,            0, 0,     32'h2);
        add(0, 0,            0,     0, 8'h08, 4'b0001, 32'h1,     0, 0,     32'h0);
        add(0, 0,            0,     1, 8'h04, 4'hF, 0,            0, 0,     st(3, 0, 0));
        add(2, 32'h3,        32'h4, 1, 8'h04, 4'hF, 0,            0, 0,     st(5, 1, 1));
        add(0, 0,            0,     0, 8'h08, 4'b1110, 32'h1,     0, 0,     32'h0);
        add(0, 0,            0,     1, 8'h04, 4'hF, 0,            0, 0,     st(5, 1, 1));
        add(0, 0,            0,     1, 8'h00, 4'hF, 0,            0, 0,     32'h4);
        add(0, 0,            0,     0, 8'h08, 4'hF, 32'h1,        0, 0,     32'h0);
        add(0, 0,            0,     1, 8'h04, 4'hF, 0,            0, 0,     st(5, 0, 0));
        add(1, 32'h2,        0,     1, 8'h00, 4'hF, 0,            1, 32'h55, 32'h2);
        add(0, 0,            0,     1, 8'h04, 4'hF, 0,            0, 0,     st(7, 0, 1));
        add(0, 0,            0,     1, 8'h00, 4'hF, 0,            0, 0,     32'h55);
        add(0, 0,            0,     1, 8'h0C, 4'hF, 0,            0, 0,     32'h0);
        add(0, 0,            0,     0, 8'h0C, 4'hF, 32'hFFFFFFFF, 0, 0,     32'h0);
        add(0, 0,            0,     0, 8'h00, 4'hF, 32'hFFFFFFFF, 0, 0,     32'h0);
        add(0, 0,            0,     0, 8'h04, 4'hF, 32'hFFFFFFFF, 0, 0,     32'h0);
        add(0, 0,            0,     1, 8'h00, 4'hF, 0,            0, 0,     32'h55);
        add(0, 0,            0,     1, 8'h08, 4'hF, 0,            0, 0,     32'h0);
        add(0, 0,            0,     1, 8'h04, 4'hF, 0,            0, 0,     st(7, 0, 0));
        add(0, 0,            0,     0, 8'h08, 4'b0001, 32'h2,     0, 0,     32'h0);
        add(0, 0,            0,     1, 8'h04, 4'hF, 0,            0, 0,     st(0, 0, 0));

        foreach (vecs[i]) begin
            if (vecs[i].ncap > 0) capture(vecs[i].cap0);
            if (vecs[i].ncap > 1) capture(vecs[i].cap1);
            xfer($sformatf("vec%0d", i), vecs[i].rnw, vecs[i].off, vecs[i].be, vecs[i].wd,
                 vecs[i].cap_ack, vecs[i].capv, vecs[i].exp);
        end

        // Select held for 4 cycles on a DATA read: one ack, bus quiet otherwise.
        @(posedge clk); #1;
        bus.OPB_ABus = BASE; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
        exp_q.push_back(32'h55);
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.Sl_xferAck) begin
                acks++;
                e = exp_q.pop_front();
                chk("hold data", bus.Sl_DBus, e);
            end else begin
                chk($sformatf("hold dbus idle %0d", i), bus.Sl_DBus, 32'h0);
            end
            if (i == 3) bus.OPB_select = 1'b0;
        end
        chk("hold ack count", acks, 1);
        exp_q.delete();

        // Address outside the window: never acked.
        @(posedge clk); #1;
        bus.OPB_ABus = 32'h12345600; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
        acks = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.Sl_xferAck) acks++;
        end
        bus.OPB_select = 1'b0;
        chk("miss ack count", acks, 0);

        // Counter saturation and CONTROL clear of count and overflow.
        @(posedge clk); #1;
        uvalid = 1'b1; udata = 32'hA5A5A5A5;
        repeat (NSAT) @(posedge clk);
        #1;
        uvalid = 1'b0;
        xfer("sat status", 1'b1, 8'h04, 4'hF, 0, 1'b0, 0, st(16'hFFFF, 1, 1));
        xfer("sat clear", 1'b0, 8'h08, 4'b0001, 32'h3, 1'b0, 0, 32'h0);
        xfer("sat after", 1'b1, 8'h04, 4'hF, 0, 1'b0, 0, st(0, 0, 1));

        // Reset asserted with a transfer in flight: no ack, state cleared.
        @(posedge clk); #1;
        bus.OPB_ABus = BASE; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1; rst = 1'b1;
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.Sl_xferAck) acks++;
        end
        bus.OPB_select = 1'b0; rst = 1'b0;
        chk("reset xfer ack count", acks, 0);
        xfer("post reset data", 1'b1, 8'h00, 4'hF, 0, 1'b0, 0, 32'h0);
        xfer("post reset status", 1'b1, 8'h04, 4'hF, 0, 1'b0, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
